// File: rtl/stopwatch_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : stopwatch_pkg
 * Purpose  : Shared types and defaults for the stopwatch button debouncer.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_t;

  localparam int DEB_STABLE_TICKS_DEFAULT = 10;
  localparam int DEB_NUM_BTNS_DEFAULT     = 4;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
/*------------------------------------------------------------------------------
 * Module   : btn_debounce_ch
 * Purpose  : One debounce channel: 2-FF synchronizer, tick-sampled FSM with
 *            stability counter, registered level and press/release strobes.
 *            Release strobe exists only when BTN_DEBOUNCE_RELEASE_EN is defined.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module btn_debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int               c_CW   = $clog2(STABLE_TICKS + 1);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(STABLE_TICKS - 1);

  logic [1:0]      r_sync;
  deb_state_t      r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_level;
  logic            r_press;
  logic            w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_state <= REL;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (i_tick) begin
        case (r_state)
          REL: begin
            if (w_s) begin
              if (STABLE_TICKS == 1) begin
                r_state <= HELD;
                r_level <= 1'b1;
                r_press <= 1'b1;
              end else begin
                r_state <= PRESS_WAIT;
                r_cnt   <= c_CW'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (!w_s) begin
              r_state <= REL;
              r_cnt   <= '0;
            end else if (r_cnt == c_LAST) begin
              r_state <= HELD;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          HELD: begin
            if (!w_s) begin
              if (STABLE_TICKS == 1) begin
                r_state <= REL;
                r_level <= 1'b0;
              end else begin
                r_state <= REL_WAIT;
                r_cnt   <= c_CW'(1);
              end
            end
          end
          REL_WAIT: begin
            if (w_s) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else if (r_cnt == c_LAST) begin
              r_state <= REL;
              r_cnt   <= '0;
              r_level <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= REL;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

`ifdef BTN_DEBOUNCE_RELEASE_EN
  // Same commit condition as the HELD->REL transitions in the FSM above.
  logic w_commit_rel;
  logic r_release;

  assign w_commit_rel = i_tick && !w_s &&
                        (((r_state == HELD) && (STABLE_TICKS == 1)) ||
                         ((r_state == REL_WAIT) && (r_cnt == c_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_release <= 1'b0;
    end else begin
      r_release <= w_commit_rel;
    end
  end

  assign o_release = r_release;
`else
  assign o_release = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
/*------------------------------------------------------------------------------
 * Module   : btn_debounce
 * Purpose  : Multi-channel push-button debouncer sampled on a shared tick.
 *            Optional release strobes via BTN_DEBOUNCE_RELEASE_EN.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int NUM_BTNS     = DEB_NUM_BTNS_DEFAULT,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (tick),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end

endmodule

`default_nettype wire
